// File: rtl/ir_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Pure definitions: no latency, no flow control.
package ir_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  function automatic logic pc_aligned(input logic [INSTR_W-1:0] pc);
    return pc[1:0] == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Memory-wait counter: clear on entry to REQ, count each unanswered REQ cycle.
// expired is combinational and flags the cycle whose increment would reach MAX_WAIT.
// No backpressure; the counter saturates instead of wrapping.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] count_q;

  assign expired = (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// IR fetch sequencer: start -> memory read -> one-cycle IR load -> hold until done.
// Latency: IR_in two cycles after start at best; waits on imem_ready indefinitely.
// IR_FETCH_TIMEOUT_EN adds a wait timeout that faults after MAX_WAIT REQ cycles.
module ir_fetch_ctrl
  import ir_fetch_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               IR_in,
  output logic [INSTR_W-1:0] IR_wdata,
  output logic               IR_out,
  output logic               ir_valid,
  input  logic               done,
  output logic               busy,
  output logic               fault
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;

`ifdef IR_FETCH_TIMEOUT_EN
  logic wait_clr;
  logic wait_inc;
  logic wait_expired;

  // Counter restarts on every entry into REQ, including back-to-back fetches.
  assign wait_clr = (state_d == ST_REQ) && (state_q != ST_REQ);
  assign wait_inc = (state_q == ST_REQ) && !imem_ready;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!pc_aligned(pc)) begin
            state_d = ST_FAULT;
          end else begin
            addr_d  = pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (imem_ready) begin
          data_d  = imem_rdata;
          state_d = ST_LOAD;
        end
`ifdef IR_FETCH_TIMEOUT_EN
        else if (wait_expired) begin
          state_d = ST_FAULT;
        end
`endif
      end
      ST_LOAD: state_d = ST_HOLD;
      ST_HOLD: begin
        if (done) begin
          if (!start) begin
            state_d = ST_IDLE;
          end else if (!pc_aligned(pc)) begin
            state_d = ST_FAULT;
          end else begin
            addr_d  = pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // IR_wdata comes straight from the capture register so it is settled for the IR's load edge.
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = (state_q == ST_REQ) ? addr_q : '0;
  assign IR_in     = (state_q == ST_LOAD);
  assign IR_wdata  = data_q;
  assign IR_out    = (state_q == ST_HOLD);
  assign ir_valid  = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: doc/ir_fetch_ctrl.md
Name: ir_fetch_ctrl

Overview:
- Fetch-side sequencer that drives the instruction register's load/output strobes in the multi-cycle CPU.
- On a start pulse it:
  - issues one instruction-memory read at the PC;
  - waits for the memory ready handshake;
  - pulses IR_in with the fetched word;
  - holds IR_out/ir_valid until the control FSM signals execute complete.
- Sits between the main control FSM, instruction memory and the IR.

Parameters:
- MAX_WAIT, 15: memory wait cycles tolerated before timeout fault (only with IR_FETCH_TIMEOUT_EN).
- WAIT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request next fetch; sampled only in IDLE (or HOLD together with done).
- pc  input  32  address of the instruction to fetch; sampled with start.
- imem_req  output  1  memory read request.
- imem_addr  output  32  latched fetch address.
- imem_ready  input  1  memory data valid this cycle.
- imem_rdata  input  32  memory read data.
- IR_in  output  1  IR load strobe.
- IR_wdata  output  32  word to load into IR.
- IR_out  output  1  IR read enable.
- ir_valid  output  1  IR content valid for decode.
- done  input  1  execute/writeback complete; releases IR.
- busy  output  1  high in every state except IDLE.
- fault  output  1  sticky misaligned-PC / timeout flag.

Behaviour:
- All logic is synchronous to posedge clk.
- Reset is synchronous and active-high: rst high at a posedge forces state IDLE, all outputs 0, the address/data latches to 0 and the wait counter to 0. This applies from any state, including mid-request.
- States: IDLE, REQ, LOAD, HOLD, FAULT.
- IDLE:
  - outputs 0.
  - start=1 with pc[1:0]!=0 -> FAULT.
  - start=1 with aligned pc -> latch pc into addr register, clear wait counter -> REQ.
- REQ:
  - imem_req=1, imem_addr=latched address.
  - imem_ready=1 -> capture imem_rdata -> LOAD. Earliest: IR_in one cycle after the ready cycle.
  - Otherwise the counter increments; requests are never dropped.
- LOAD:
  - IR_in=1 for exactly one clk period; IR_wdata=captured word.
  - IR_wdata stays stable at the captured value until the next capture, so the IR's falling-edge load sees settled data.
  - Next state is HOLD unconditionally.
- HOLD:
  - IR_out=1, ir_valid=1.
  - done=0 -> stay.
  - done=1, start=0 -> IDLE.
  - done=1, start=1 -> back-to-back fetch: misaligned pc -> FAULT, else latch pc -> REQ.
- FAULT:
  - fault=1, busy=1, all other strobes 0.
  - Left only by rst.
- Minimum fetch latency: start at cycle 0, ready at cycle 1, IR_in at cycle 2, ir_valid from cycle 3.
- start outside IDLE/HOLD+done is ignored, not queued.
- done outside HOLD is ignored.
- imem_ready outside REQ is ignored.
- imem_addr is 0 outside REQ.

Optional Feature:
- Macro: IR_FETCH_TIMEOUT_EN.
- Defined: in REQ, if the wait counter reaches MAX_WAIT with imem_ready still 0, go to FAULT on that edge. imem_ready in that same cycle wins, i.e. a normal capture.
- Undefined: no counter logic is generated, REQ waits indefinitely, and only a misaligned PC raises fault.

Decomposition:
- Shared package ir_fetch_pkg holds:
  - state encoding constants (IDLE=0, REQ=1, LOAD=2, HOLD=3, FAULT=4; 3 bits);
  - instruction width 32;
  - the alignment mask 2'b00.
- One natural sub-module: fetch_wait_timer. It is a WAIT_W-bit clear/increment counter with an expired flag, instantiated only under IR_FETCH_TIMEOUT_EN.

Test Plan:
- Reset then start with pc=0x00400000 and imem_ready=1 in the first REQ cycle, rdata=0x20080005:
  - imem_addr=0x00400000;
  - IR_in high exactly one cycle with IR_wdata=0x20080005;
  - ir_valid held until done.
- Ready after 3 wait cycles, rdata=0x8C090004: imem_req held 4 cycles, then a single IR_in pulse, then HOLD.
- start with pc=0x00400002: fault=1 next cycle, imem_req never asserted; only rst clears fault.
- In HOLD, assert done and start together with pc=0x00400004: direct transition to REQ with imem_addr=0x00400004 and no IDLE cycle.
- rst asserted mid-REQ:
  - next posedge gives state IDLE and all outputs 0;
  - later imem_ready=1 causes no IR_in.
- With IR_FETCH_TIMEOUT_EN defined, MAX_WAIT=15, imem_ready never asserted: fault=1 after 15 REQ cycles. Repeat with ready on cycle 15: normal load, no fault.
